// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   DEFAULT_WIDTH : default operand/result width (legal range 1..32)
//   state_t       : controller states IDLE / SHIFT / DONE
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the bit-serial adder.
//   start, a, b            : request side (driven by the master)
//   busy, done, sum, cout  : status/result side (driven by the adder)
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout
    );

endinterface

// File: rtl/full_adder.sv
// Single-bit full adder built from two half adders with the carries ORed.
//   a, b, cin : addend bits and carry in
//   s, co     : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s0),
        .c (c0)
    );

    half_adder u_ha1 (
        .a (s0),
        .b (cin),
        .s (s),
        .c (c1)
    );

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// Single-bit half adder.
//   a, b : addend bits
//   s    : sum bit
//   c    : carry bit
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a+b LSB-first, one bit per clock, through a single
// full-adder cell and a carry flop. One add takes WIDTH SHIFT cycles plus a
// DONE cycle; sum/cout only change when a result completes.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : start/a/b request, busy/done/sum/cout result (slave side)
// WIDTH must lie in 1..32.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    // One extra bit so the counter can hold WIDTH itself (WIDTH=32 needs 6 bits).
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             s_bit;
    logic             c_next;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    full_adder u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (s_bit),
        .co  (c_next)
    );

    // Result register shifts right, new bit enters at the MSB; written this
    // way so that WIDTH=1 needs no zero-width slice.
    always_comb begin
        res_next            = res_sh >> 1;
        res_next[WIDTH-1]   = s_bit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    carry  <= c_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    // Last bit: publish the finished word straight from the
                    // combinational next value so partial results never show.
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum_q  <= res_next;
                        cout_q <= c_next;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH = 8, 1 and 32.
// Issued requests push the expected {sum, cout, done cycle} into a queue;
// per-width monitors pop and compare whenever done is seen.
module tb_serial_adder;
    import serial_adder_pkg::*;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        int          done_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   acc8 = 0, acc1 = 0, acc32 = 0;
    int   dn8 = 0, dn1 = 0, dn32 = 0;
    int   last_acc = 0;
    int   first_acc = 0;
    logic [7:0] held_sum8 = '0;
    logic       held_cout8 = 1'b0;
    exp_t q8[$];
    exp_t q1[$];
    exp_t q32[$];

    serial_adder_if #(.WIDTH(8))  bus8 ();
    serial_adder_if #(.WIDTH(1))  bus1 ();
    serial_adder_if #(.WIDTH(32)) bus32 ();

    serial_adder #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_adder #(.WIDTH(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    serial_adder #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain integer addition, result split at bit w.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input int w, input int acc_cyc);
        exp_t m;
        longint unsigned mask;
        longint unsigned t;
        mask       = (64'd1 << w) - 64'd1;
        t          = (longint'(a) & mask) + (longint'(b) & mask);
        m.sum      = 32'(t & mask);
        m.cout     = 1'((t >> w) & 64'd1);
        m.done_cyc = acc_cyc + w;
        return m;
    endfunction

    function automatic logic done_of(input int w);
        return (w == 1) ? bus1.done : (w == 32) ? bus32.done : bus8.done;
    endfunction

    function automatic logic busy_of(input int w);
        return (w == 1) ? bus1.busy : (w == 32) ? bus32.busy : bus8.busy;
    endfunction

    // Called at a negedge while the selected adder is idle.
    task automatic issue(input int w, input logic [31:0] a, input logic [31:0] b, input bit push);
        case (w)
            1:       begin bus1.start = 1'b1;  bus1.a = a[0];      bus1.b = b[0];      end
            32:      begin bus32.start = 1'b1; bus32.a = a;        bus32.b = b;        end
            default: begin bus8.start = 1'b1;  bus8.a = a[7:0];    bus8.b = b[7:0];    end
        endcase
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (push) begin
            case (w)
                1:       begin q1.push_back(model(a, b, 1, cyc));   acc1++;  end
                32:      begin q32.push_back(model(a, b, 32, cyc)); acc32++; end
                default: begin q8.push_back(model(a, b, 8, cyc));   acc8++;  end
            endcase
        end
        check("busy_after_accept", 64'(busy_of(w)), 64'd1);
        bus1.start  = 1'b0; bus1.a  = 1'($urandom);  bus1.b  = 1'($urandom);
        bus8.start  = 1'b0; bus8.a  = 8'($urandom);  bus8.b  = 8'($urandom);
        bus32.start = 1'b0; bus32.a = $urandom;      bus32.b = $urandom;
    endtask

    // Returns at the negedge of the done cycle; the bound is a cycle budget.
    task automatic wait_done(input int w, input bit noise, input bit keep);
        bit seen = 1'b0;
        for (int i = 0; i < w + 4; i++) begin
            @(negedge clk);
            if (done_of(w)) begin
                seen = 1'b1;
                break;
            end
            if (noise) begin
                bus8.start = 1'($urandom_range(0, 1));
                bus8.a     = 8'($urandom);
                bus8.b     = 8'($urandom);
            end
        end
        check("done_seen_in_budget", 64'(seen), 64'd1);
        if (seen) check("busy_low_at_done", 64'(busy_of(w)), 64'd0);
        if (!keep) begin
            bus1.start  = 1'b0;
            bus8.start  = 1'b0;
            bus32.start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus8.done) begin
                if (q8.size() == 0) begin
                    check("done8_unexpected", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = q8.pop_front();
                    dn8++;
                    check("sum8", 64'(bus8.sum), 64'(e.sum[7:0]));
                    check("cout8", 64'(bus8.cout), 64'(e.cout));
                    check("done8_cycle", 64'(cyc), 64'(e.done_cyc));
                    held_sum8  = e.sum[7:0];
                    held_cout8 = e.cout;
                end
            end else begin
                check("sum8_hold", 64'(bus8.sum), 64'(held_sum8));
                check("cout8_hold", 64'(bus8.cout), 64'(held_cout8));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus1.done) begin
            if (q1.size() == 0) begin
                check("done1_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                dn1++;
                check("sum1", 64'(bus1.sum), 64'(e.sum[0]));
                check("cout1", 64'(bus1.cout), 64'(e.cout));
                check("done1_cycle", 64'(cyc), 64'(e.done_cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus32.done) begin
            if (q32.size() == 0) begin
                check("done32_unexpected", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = q32.pop_front();
                dn32++;
                check("sum32", 64'(bus32.sum), 64'(e.sum));
                check("cout32", 64'(bus32.cout), 64'(e.cout));
                check("done32_cycle", 64'(cyc), 64'(e.done_cyc));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        bus1.start = 1'b0;  bus1.a = '0;  bus1.b = '0;
        bus8.start = 1'b0;  bus8.a = '0;  bus8.b = '0;
        bus32.start = 1'b0; bus32.a = '0; bus32.b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy8", 64'(bus8.busy), 64'd0);
        check("rst_done8", 64'(bus8.done), 64'd0);
        check("rst_sum8", 64'(bus8.sum), 64'd0);
        check("rst_cout8", 64'(bus8.cout), 64'd0);

        // First start accepted on the first edge after release; 0+0.
        rst_n = 1'b1;
        issue(8, 32'h00, 32'h00, 1'b1);
        wait_done(8, 1'b0, 1'b0);

        // Overflow then back-to-back.
        @(negedge clk);
        issue(8, 32'hFF, 32'h01, 1'b1);
        first_acc = last_acc;
        wait_done(8, 1'b0, 1'b0);
        @(negedge clk);
        issue(8, 32'h5A, 32'h3C, 1'b1);
        check("back_to_back_period", 64'(last_acc - first_acc), 64'd10);
        wait_done(8, 1'b0, 1'b0);

        // start held high with new operands through SHIFT and DONE is ignored.
        @(negedge clk);
        issue(8, 32'h80, 32'h80, 1'b1);
        bus8.start = 1'b1; bus8.a = 8'h01; bus8.b = 8'h01;
        wait_done(8, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        repeat (4) @(negedge clk);
        check("no_second_request", 64'(bus8.busy), 64'd0);

        // Reset in the middle of SHIFT aborts with no done pulse.
        issue(8, 32'hAA, 32'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        held_sum8  = '0;
        held_cout8 = 1'b0;
        #1;
        check("abort_busy", 64'(bus8.busy), 64'd0);
        check("abort_done", 64'(bus8.done), 64'd0);
        check("abort_sum", 64'(bus8.sum), 64'd0);
        check("abort_cout", 64'(bus8.cout), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_abort", 64'(bus8.busy), 64'd0);
        issue(8, 32'h01, 32'h02, 1'b1);
        wait_done(8, 1'b0, 1'b0);

        // Randomized run with random gaps (0 = back-to-back) and start noise.
        repeat (1000) begin
            repeat ($urandom_range(0, 2) + 1) @(negedge clk);
            issue(8, $urandom, $urandom, 1'b1);
            wait_done(8, 1'b1, 1'b0);
        end

        // WIDTH = 1.
        @(negedge clk);
        issue(1, 32'h1, 32'h1, 1'b1);
        wait_done(1, 1'b0, 1'b0);
        repeat (20) begin
            repeat ($urandom_range(0, 2) + 1) @(negedge clk);
            issue(1, $urandom, $urandom, 1'b1);
            wait_done(1, 1'b0, 1'b0);
        end

        // WIDTH = 32.
        @(negedge clk);
        issue(32, 32'hFFFF_FFFF, 32'h1, 1'b1);
        wait_done(32, 1'b0, 1'b0);
        repeat (20) begin
            repeat ($urandom_range(0, 2) + 1) @(negedge clk);
            issue(32, $urandom, $urandom, 1'b1);
            wait_done(32, 1'b0, 1'b0);
        end

        repeat (4) @(negedge clk);
        check("dones_vs_accepts8", 64'(dn8), 64'(acc8));
        check("dones_vs_accepts1", 64'(dn1), 64'(acc1));
        check("dones_vs_accepts32", 64'(dn32), 64'(acc32));
        check("queues_drained", 64'(q8.size() + q1.size() + q32.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
